// File: rtl/score_display_pkg.sv
// Shared constants for the score display.
// Holds the active-low glyph codes, the BCD-to-segment table, the digit-index
// enumeration and the "all anodes off" pattern. Segment order is {g,f,e,d,c,b,a}.
package score_display_pkg;

  // Non-numeric glyphs, active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH_H     = 7'b0001001;
  localparam logic [6:0] GLYPH_L     = 7'b1000111;
  localparam logic [6:0] GLYPH_D     = 7'b0100001;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  // BCD segment table, element [n] is the pattern for digit n
  localparam logic [9:0][6:0] BCD_SEG_TABLE = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  localparam logic [3:0] AN_OFF = 4'b1111;

  // Scan position; the numeric value is also the anode bit driven low
  typedef enum logic [1:0] {
    DIG_UNITS    = 2'd0,
    DIG_TENS     = 2'd1,
    DIG_HUNDREDS = 2'd2,
    DIG_GLYPH    = 2'd3
  } digit_e;

endpackage

// File: rtl/score_display_seg7_encode.sv
// seg7_encode: combinational BCD to 7-segment encoder.
// Ports:
//   bcd  in  4  BCD digit; codes 10..15 are shown as a dash
//   seg  out 7  active-low cathodes {g,f,e,d,c,b,a}
module seg7_encode
  import score_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH_DASH;
    if (bcd < 4'd10) begin
      seg = BCD_SEG_TABLE[bcd];
    end
  end

endmodule

// File: rtl/score_display.sv
// score_display: 4-digit multiplexed 7-segment driver for the puzzle timer.
// Digits 0..2 show the units/tens/hundreds of either the countdown or the
// high score; digit 3 shows a mode glyph (H, L, d or blank). All values shown
// in one scan frame come from a snapshot taken when the scan wraps 3->0, so a
// frame never mixes old and new digits. While the timer has expired (and the
// high score is not selected) the whole display blinks.
// Ports:
//   clk_high                 in  1  sole clock
//   clr_n                    in  1  synchronous active-low reset
//   sec_u, sec_t, sec_h      in  4  countdown BCD digits
//   h_sec_u, h_sec_t, h_sec_h in 4  high-score BCD digits
//   lose_flag, win_flag      in  1  timer expired / puzzle solved
//   show_high                in  1  asynchronous switch, 1 = show high score
//   an                       out 4  active-low one-hot anodes, an[0] rightmost
//   seg                      out 7  active-low cathodes {g,f,e,d,c,b,a}
//   dp                       out 1  active-low decimal point (always off)
module score_display
  import score_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_TICKS = 250
) (
  input  logic       clk_high,
  input  logic       clr_n,
  input  logic [3:0] sec_u,
  input  logic [3:0] sec_t,
  input  logic [3:0] sec_h,
  input  logic [3:0] h_sec_u,
  input  logic [3:0] h_sec_t,
  input  logic [3:0] h_sec_h,
  input  logic       lose_flag,
  input  logic       win_flag,
  input  logic       show_high,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [REF_W-1:0]   REF_LAST   = REF_W'(REFRESH_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

  logic [REF_W-1:0]   refresh_cnt_reg;
  logic [BLINK_W-1:0] blink_cnt_reg;
  logic               blink_phase_reg;
  digit_e             digit_idx_reg;
  logic [1:0]         show_high_sync_reg;
  logic [2:0][3:0]    snap_sec_reg;
  logic [2:0][3:0]    snap_hsec_reg;
  logic               snap_high_reg;
  logic               snap_lose_reg;
  logic               snap_win_reg;
  logic               out_en_reg;
  logic [3:0]         an_reg;
  logic [6:0]         seg_reg;

  logic               scan_tick;
  logic               frame_wrap;
  logic [2:0][3:0]    sec_in;
  logic [2:0][3:0]    hsec_in;
  logic [2:0][6:0]    digit_seg;
  logic [3:0]         an_next;
  logic [6:0]         seg_next;

  assign sec_in  = {sec_h, sec_t, sec_u};
  assign hsec_in = {h_sec_h, h_sec_t, h_sec_u};

  assign scan_tick  = (refresh_cnt_reg == REF_LAST);
  assign frame_wrap = scan_tick && (digit_idx_reg == DIG_GLYPH);

  // One encoder per numeric digit, fed from the snapshot of the selected mode
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_digit
      logic [3:0] digit_bcd;
      assign digit_bcd = snap_high_reg ? snap_hsec_reg[gi] : snap_sec_reg[gi];
      seg7_encode u_enc (
        .bcd (digit_bcd),
        .seg (digit_seg[gi])
      );
    end
  endgenerate

  always_comb begin
    an_next  = AN_OFF;
    seg_next = GLYPH_BLANK;
    case (digit_idx_reg)
      DIG_UNITS: begin
        an_next  = 4'b1110;
        seg_next = digit_seg[0];
      end
      DIG_TENS: begin
        an_next  = 4'b1101;
        seg_next = digit_seg[1];
      end
      DIG_HUNDREDS: begin
        an_next  = 4'b1011;
        seg_next = digit_seg[2];
      end
      default: begin
        an_next = 4'b0111;
        if (snap_high_reg)     seg_next = GLYPH_H;
        else if (snap_lose_reg) seg_next = GLYPH_L;
        else if (snap_win_reg)  seg_next = GLYPH_D;
        else                    seg_next = GLYPH_BLANK;
      end
    endcase
    // Blink only gates the anodes; the cathode pattern keeps tracking the scan
    if (snap_lose_reg && !snap_high_reg && blink_phase_reg) begin
      an_next = AN_OFF;
    end
    // Keeps the display dark for one extra cycle after reset is released
    if (!out_en_reg) begin
      an_next  = AN_OFF;
      seg_next = GLYPH_BLANK;
    end
  end

  always_ff @(posedge clk_high) begin
    if (!clr_n) begin
      refresh_cnt_reg    <= '0;
      blink_cnt_reg      <= '0;
      blink_phase_reg    <= 1'b0;
      digit_idx_reg      <= DIG_UNITS;
      show_high_sync_reg <= 2'b00;
      snap_sec_reg       <= '0;
      snap_hsec_reg      <= '0;
      snap_high_reg      <= 1'b0;
      snap_lose_reg      <= 1'b0;
      snap_win_reg       <= 1'b0;
      out_en_reg         <= 1'b0;
      an_reg             <= AN_OFF;
      seg_reg            <= GLYPH_BLANK;
    end else begin
      out_en_reg         <= 1'b1;
      an_reg             <= an_next;
      seg_reg            <= seg_next;
      show_high_sync_reg <= {show_high_sync_reg[0], show_high};

      if (scan_tick) begin
        refresh_cnt_reg <= '0;
        digit_idx_reg   <= digit_e'(digit_idx_reg + 2'd1);
      end else begin
        refresh_cnt_reg <= refresh_cnt_reg + 1'b1;
      end

      if (frame_wrap) begin
        snap_sec_reg  <= sec_in;
        snap_hsec_reg <= hsec_in;
        snap_high_reg <= show_high_sync_reg[1];
        snap_lose_reg <= lose_flag;
        snap_win_reg  <= win_flag;
      end

      // The blink decision uses the lose snapshot held before this edge, so a
      // frame wrap that coincides with a blink terminal still toggles the
      // phase from its pre-toggle value.
      if (!snap_lose_reg) begin
        blink_cnt_reg   <= '0;
        blink_phase_reg <= 1'b0;
      end else if (scan_tick) begin
        if (blink_cnt_reg == BLINK_LAST) begin
          blink_cnt_reg   <= '0;
          blink_phase_reg <= ~blink_phase_reg;
        end else begin
          blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_score_display.sv
// Directed testbench for score_display with REFRESH_DIV=4, BLINK_TICKS=2.
// One scan step is 4 clocks, one frame is 16 clocks. Outputs are sampled on
// the falling edge.
module tb_score_display;

  logic       clk_high;
  logic       clr_n;
  logic [3:0] sec_u, sec_t, sec_h;
  logic [3:0] h_sec_u, h_sec_t, h_sec_h;
  logic       lose_flag, win_flag, show_high;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int tests_run;
  int tests_failed;

  score_display #(
    .REFRESH_DIV (4),
    .BLINK_TICKS (2)
  ) dut (
    .clk_high  (clk_high),
    .clr_n     (clr_n),
    .sec_u     (sec_u),
    .sec_t     (sec_t),
    .sec_h     (sec_h),
    .h_sec_u   (h_sec_u),
    .h_sec_t   (h_sec_t),
    .h_sec_h   (h_sec_h),
    .lose_flag (lose_flag),
    .win_flag  (win_flag),
    .show_high (show_high),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  initial clk_high = 1'b0;
  always #5 clk_high = ~clk_high;

  // Bounded wait until the anodes show the requested pattern
  task automatic wait_an(input logic [3:0] target, input string what);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk_high);
      if (an === target) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL wait_%s: an=%b never reached %b", what, an, target);
    end
  endtask

  // Sample one frame starting at the current (first) cycle of slot 0
  task automatic grab_frame(output logic [15:0] ans, output logic [27:0] segs,
                            output logic [3:0] dps);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) repeat (4) @(negedge clk_high);
      ans[4*i +: 4]  = an;
      segs[7*i +: 7] = seg;
      dps[i]         = dp;
    end
  endtask

  task automatic test_reset();
    sec_u = 4'd9; sec_t = 4'd9; sec_h = 4'd9;
    h_sec_u = 4'd0; h_sec_t = 4'd0; h_sec_h = 4'd0;
    lose_flag = 1'b0; win_flag = 1'b0; show_high = 1'b0;
    clr_n = 1'b0;
    repeat (3) @(negedge clk_high);
    tests_run++;
    if (an !== 4'b1111) begin tests_failed++; $display("FAIL reset_an: got %b want 1111", an); end
    tests_run++;
    if (seg !== 7'b1111111) begin tests_failed++; $display("FAIL reset_seg: got %b want 1111111", seg); end
    tests_run++;
    if (dp !== 1'b1) begin tests_failed++; $display("FAIL reset_dp: got %b want 1", dp); end
    clr_n = 1'b1;
    @(negedge clk_high);
    tests_run++;
    if (an !== 4'b1111) begin tests_failed++; $display("FAIL post_reset_an: got %b want 1111", an); end
    tests_run++;
    if (seg !== 7'b1111111) begin tests_failed++; $display("FAIL post_reset_seg: got %b want 1111111", seg); end
    @(negedge clk_high);
    tests_run++;
    if (an !== 4'b1110) begin tests_failed++; $display("FAIL first_digit_an: got %b want 1110", an); end
    // Snapshot is still the reset value, so units shows 0 not 9
    tests_run++;
    if (seg !== 7'b1000000) begin tests_failed++; $display("FAIL first_digit_seg: got %b want 1000000", seg); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_scan();
    logic [15:0] ans;
    logic [27:0] segs;
    logic [3:0]  dps;
    wait_an(4'b1101, "scan_idx1");
    repeat (4) @(negedge clk_high);
    tests_run++;
    if (an !== 4'b1011) begin tests_failed++; $display("FAIL scan_idx2: got %b want 1011", an); end
    repeat (4) @(negedge clk_high);
    tests_run++;
    if (an !== 4'b0111) begin tests_failed++; $display("FAIL scan_idx3: got %b want 0111", an); end
    repeat (4) @(negedge clk_high);
    tests_run++;
    if (an !== 4'b1110) begin tests_failed++; $display("FAIL scan_wrap: got %b want 1110", an); end
    grab_frame(ans, segs, dps);
    tests_run++;
    if (ans !== 16'b0111_1011_1101_1110) begin tests_failed++; $display("FAIL scan_an_seq: got %b want 0111101111011110", ans); end
    tests_run++;
    if (segs !== {7'b1111111, 7'b0010000, 7'b0010000, 7'b0010000}) begin
      tests_failed++; $display("FAIL scan_nines: got %b", segs);
    end
    tests_run++;
    if (dps !== 4'b1111) begin tests_failed++; $display("FAIL scan_dp: got %b want 1111", dps); end
    $display("[TB] test_scan done");
  endtask

  task automatic test_high();
    logic [15:0] ans;
    logic [27:0] segs;
    logic [3:0]  dps;
    wait_an(4'b1110, "high_start");
    sec_u = 4'd1; sec_t = 4'd2; sec_h = 4'd3;
    h_sec_u = 4'd2; h_sec_t = 4'd0; h_sec_h = 4'd0;
    show_high = 1'b1;
    wait_an(4'b0111, "high_glyph_prev");
    wait_an(4'b1110, "high_frame");
    grab_frame(ans, segs, dps);
    tests_run++;
    if (segs[6:0] !== 7'b0100100) begin tests_failed++; $display("FAIL high_units: got %b want 0100100", segs[6:0]); end
    tests_run++;
    if (segs[13:7] !== 7'b1000000) begin tests_failed++; $display("FAIL high_tens: got %b want 1000000", segs[13:7]); end
    tests_run++;
    if (segs[20:14] !== 7'b1000000) begin tests_failed++; $display("FAIL high_hund: got %b want 1000000", segs[20:14]); end
    tests_run++;
    if (segs[27:21] !== 7'b0001001) begin tests_failed++; $display("FAIL high_glyph: got %b want 0001001", segs[27:21]); end
    tests_run++;
    if (ans[15:12] !== 4'b0111) begin tests_failed++; $display("FAIL high_glyph_an: got %b want 0111", ans[15:12]); end
    $display("[TB] test_high done");
  endtask

  task automatic test_tearing();
    wait_an(4'b1110, "tear_start");
    show_high = 1'b0;
    sec_u = 4'd5; sec_t = 4'd0; sec_h = 4'd0;
    wait_an(4'b0111, "tear_glyph_prev");
    wait_an(4'b1110, "tear_frame");
    tests_run++;
    if (seg !== 7'b0010010) begin tests_failed++; $display("FAIL tear_units5: got %b want 0010010", seg); end
    sec_u = 4'd4; sec_t = 4'd7;
    wait_an(4'b1101, "tear_idx1");
    tests_run++;
    if (seg !== 7'b1000000) begin tests_failed++; $display("FAIL tear_tens_held: got %b want 1000000", seg); end
    wait_an(4'b0111, "tear_glyph");
    wait_an(4'b1110, "tear_next");
    tests_run++;
    if (seg !== 7'b0011001) begin tests_failed++; $display("FAIL tear_units4: got %b want 0011001", seg); end
    repeat (4) @(negedge clk_high);
    tests_run++;
    if (seg !== 7'b1111000) begin tests_failed++; $display("FAIL tear_tens7: got %b want 1111000", seg); end
    $display("[TB] test_tearing done");
  endtask

  task automatic test_lose_blink();
    logic [3:0]  exp_an [8];
    logic [15:0] ans;
    logic [27:0] segs;
    logic [3:0]  dps;
    exp_an = '{4'b1110, 4'b1101, 4'b1111, 4'b1111, 4'b1110, 4'b1101, 4'b1111, 4'b1111};
    wait_an(4'b1110, "lose_start");
    sec_u = 4'd0; sec_t = 4'd0; sec_h = 4'd0;
    lose_flag = 1'b1;
    wait_an(4'b0111, "lose_glyph_prev");
    wait_an(4'b1110, "lose_frame");
    for (int k = 0; k < 8; k++) begin
      if (k > 0) repeat (4) @(negedge clk_high);
      tests_run++;
      if (an !== exp_an[k]) begin tests_failed++; $display("FAIL blink_step%0d: got %b want %b", k, an, exp_an[k]); end
      if (k == 0) begin
        tests_run++;
        if (seg !== 7'b1000000) begin tests_failed++; $display("FAIL lose_units: got %b want 1000000", seg); end
      end
      if (k == 3) begin
        tests_run++;
        if (seg !== 7'b1000111) begin tests_failed++; $display("FAIL lose_glyph: got %b want 1000111", seg); end
      end
    end
    wait_an(4'b1110, "unlose_start");
    lose_flag = 1'b0;
    repeat (16) @(negedge clk_high);
    grab_frame(ans, segs, dps);
    tests_run++;
    if (ans !== 16'b0111_1011_1101_1110) begin tests_failed++; $display("FAIL unblink_an: got %b want 0111101111011110", ans); end
    tests_run++;
    if (segs[27:21] !== 7'b1111111) begin tests_failed++; $display("FAIL unlose_glyph: got %b want 1111111", segs[27:21]); end
    $display("[TB] test_lose_blink done");
  endtask

  task automatic test_dash_priority();
    logic [15:0] ans;
    logic [27:0] segs;
    logic [3:0]  dps;
    wait_an(4'b1110, "dash_start");
    sec_u = 4'd12; lose_flag = 1'b1; win_flag = 1'b1;
    wait_an(4'b0111, "dash_glyph_prev");
    wait_an(4'b1110, "dash_frame");
    tests_run++;
    if (seg !== 7'b0111111) begin tests_failed++; $display("FAIL dash_units: got %b want 0111111", seg); end
    repeat (12) @(negedge clk_high);
    tests_run++;
    if (seg !== 7'b1000111) begin tests_failed++; $display("FAIL lose_over_win: got %b want 1000111", seg); end
    tests_run++;
    if (an !== 4'b1111) begin tests_failed++; $display("FAIL dash_blink_an: got %b want 1111", an); end
    wait_an(4'b1110, "win_start");
    lose_flag = 1'b0; sec_u = 4'd3;
    repeat (16) @(negedge clk_high);
    grab_frame(ans, segs, dps);
    tests_run++;
    if (segs[6:0] !== 7'b0110000) begin tests_failed++; $display("FAIL win_units: got %b want 0110000", segs[6:0]); end
    tests_run++;
    if (segs[27:21] !== 7'b0100001) begin tests_failed++; $display("FAIL win_glyph: got %b want 0100001", segs[27:21]); end
    tests_run++;
    if (ans[15:12] !== 4'b0111) begin tests_failed++; $display("FAIL win_glyph_an: got %b want 0111", ans[15:12]); end
    $display("[TB] test_dash_priority done");
  endtask

  task automatic test_reset_mid();
    wait_an(4'b1011, "mid_idx2");
    clr_n = 1'b0;
    @(negedge clk_high);
    tests_run++;
    if (an !== 4'b1111) begin tests_failed++; $display("FAIL mid_reset_an: got %b want 1111", an); end
    tests_run++;
    if (seg !== 7'b1111111) begin tests_failed++; $display("FAIL mid_reset_seg: got %b want 1111111", seg); end
    clr_n = 1'b1;
    @(negedge clk_high);
    tests_run++;
    if (an !== 4'b1111) begin tests_failed++; $display("FAIL mid_after_an: got %b want 1111", an); end
    tests_run++;
    if (seg !== 7'b1111111) begin tests_failed++; $display("FAIL mid_after_seg: got %b want 1111111", seg); end
    @(negedge clk_high);
    tests_run++;
    if (an !== 4'b1110) begin tests_failed++; $display("FAIL mid_restart_an: got %b want 1110", an); end
    tests_run++;
    if (seg !== 7'b1000000) begin tests_failed++; $display("FAIL mid_restart_seg: got %b want 1000000", seg); end
    repeat (3) @(negedge clk_high);
    tests_run++;
    if (an !== 4'b1101) begin tests_failed++; $display("FAIL mid_first_tick: got %b want 1101", an); end
    repeat (8) @(negedge clk_high);
    tests_run++;
    if (an !== 4'b0111) begin tests_failed++; $display("FAIL mid_glyph_an: got %b want 0111", an); end
    tests_run++;
    if (seg !== 7'b1111111) begin tests_failed++; $display("FAIL mid_glyph_blank: got %b want 1111111", seg); end
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    clr_n        = 1'b0;
    test_reset();
    test_scan();
    test_high();
    test_tearing();
    test_lose_blink();
    test_dash_priority();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
